// File: rtl/sysid_regs_pkg.sv
// rtl/sysid_regs_pkg.sv - word map, CONTROL bit indices and CAPS layout for sysid_regs
package sysid_regs_pkg;

  localparam logic [31:0] ADDR_ID        = 32'd0;
  localparam logic [31:0] ADDR_TIMESTAMP = 32'd1;
  localparam logic [31:0] ADDR_CAPS      = 32'd2;
  localparam logic [31:0] ADDR_SCRATCH   = 32'd3;
  localparam logic [31:0] ADDR_UPTIME_LO = 32'd4;
  localparam logic [31:0] ADDR_UPTIME_HI = 32'd5;
  localparam logic [31:0] ADDR_CONTROL   = 32'd6;
  localparam logic [31:0] ADDR_USER_BASE = 32'd8;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  // CAPS = {VERSION[15:0], 8'h00, NUM_USER[7:0]}
  function automatic logic [31:0] caps_word(input logic [15:0] version,
                                            input logic [7:0]  num_user);
    return {version, 8'h00, num_user};
  endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// rtl/sysid_uptime_counter.sv - 64-bit uptime counter with clear, freeze and high-word shadow
module sysid_uptime_counter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_freeze_we,
  input  logic        i_freeze_d,
  input  logic        i_capture,
  output logic [31:0] o_count_lo,
  output logic [31:0] o_shadow,
  output logic        o_freeze
);

  logic [63:0] r_count;
  logic [31:0] r_shadow;
  logic        r_freeze;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_shadow <= '0;
      r_freeze <= 1'b0;
    end else begin
      // clear wins over both increment and freeze
      if (i_clear) begin
        r_count <= '0;
      end else if (!r_freeze) begin
        r_count <= r_count + 64'd1;
      end
      if (i_freeze_we) begin
        r_freeze <= i_freeze_d;
      end
      if (i_capture) begin
        r_shadow <= r_count[63:32];
      end
    end
  end

  assign o_count_lo = r_count[31:0];
  assign o_shadow   = r_shadow;
  assign o_freeze   = r_freeze;

endmodule

// File: rtl/sysid_regs.sv
// rtl/sysid_regs.sv - Avalon-MM system ID / scratch / uptime register block
module sysid_regs
  import sysid_regs_pkg::*;
#(
  parameter logic [31:0] ID        = 32'h1234_ABCD,
  parameter logic [31:0] TIMESTAMP = 32'd0,
  parameter logic [15:0] VERSION   = 16'h0001,
  parameter int          NUM_USER  = 4,
  parameter logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] USER_INIT = '0,
  parameter int          ADDR_W    = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  if (((8 + NUM_USER) > (2 ** ADDR_W)) || (NUM_USER > 255)) begin : g_param_check
    $error("sysid_regs: NUM_USER=%0d does not fit ADDR_W=%0d", NUM_USER, ADDR_W);
  end

  logic [31:0] w_addr;
  logic        w_wr_scratch;
  logic        w_wr_ctrl;
  logic        w_clear;
  logic        w_capture;
  logic        w_freeze;
  logic [31:0] w_count_lo;
  logic [31:0] w_shadow;
  logic [31:0] w_rdata;

  logic [31:0] r_scratch;
  logic [31:0] r_readdata;
  logic        r_readdatavalid;

  assign w_addr       = 32'(address);
  assign w_wr_scratch = write && (w_addr == ADDR_SCRATCH);
  assign w_wr_ctrl    = write && (w_addr == ADDR_CONTROL) && byteenable[0];
  assign w_clear      = w_wr_ctrl && writedata[CTRL_CLEAR_BIT];
  assign w_capture    = read && (w_addr == ADDR_UPTIME_LO);

  sysid_uptime_counter u_uptime (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_clear     (w_clear),
    .i_freeze_we (w_wr_ctrl),
    .i_freeze_d  (writedata[CTRL_FREEZE_BIT]),
    .i_capture   (w_capture),
    .o_count_lo  (w_count_lo),
    .o_shadow    (w_shadow),
    .o_freeze    (w_freeze)
  );

  // Read mux sees pre-edge state, so a same-cycle write returns old data
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_ID:        w_rdata = ID;
      ADDR_TIMESTAMP: w_rdata = TIMESTAMP;
      ADDR_CAPS:      w_rdata = caps_word(VERSION, 8'(NUM_USER));
      ADDR_SCRATCH:   w_rdata = r_scratch;
      ADDR_UPTIME_LO: w_rdata = w_count_lo;
      ADDR_UPTIME_HI: w_rdata = w_shadow;
      ADDR_CONTROL:   w_rdata[CTRL_FREEZE_BIT] = w_freeze;
      default: begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (w_addr == ADDR_USER_BASE + 32'(k)) begin
            w_rdata = USER_INIT[k*32 +: 32];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
      r_scratch       <= '0;
    end else begin
      r_readdatavalid <= read;
      if (read) begin
        r_readdata <= w_rdata;
      end
      if (w_wr_scratch) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) begin
            r_scratch[8*b +: 8] <= writedata[8*b +: 8];
          end
        end
      end
    end
  end

  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_sysid_regs.sv
// tb/tb_sysid_regs.sv - directed scoreboard bench for sysid_regs (default and two-user-word builds)
module tb_sysid_regs;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;

  logic [31:0] readdata_a, readdata_b;
  logic        readdatavalid_a, readdatavalid_b;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  logic [63:0] m_cnt = '0;
  logic [31:0] m_shadow = '0;
  logic [31:0] m_scratch = '0;
  logic        m_freeze = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sysid_regs dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata_a),
    .readdatavalid (readdatavalid_a)
  );

  sysid_regs #(
    .NUM_USER  (2),
    .USER_INIT ({32'h0000_000B, 32'h0000_000A})
  ) dut_u (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata_b),
    .readdatavalid (readdatavalid_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] a, input logic user_build);
    case (a)
      4'd0:    return 32'h1234_ABCD;
      4'd1:    return 32'h0;
      4'd2:    return user_build ? 32'h0001_0002 : 32'h0001_0004;
      4'd3:    return m_scratch;
      4'd4:    return m_cnt[31:0];
      4'd5:    return m_shadow;
      4'd6:    return {30'b0, m_freeze, 1'b0};
      4'd8:    return user_build ? 32'hA : 32'h0;
      4'd9:    return user_build ? 32'hB : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    last_a    = '0;
    last_b    = '0;
    m_cnt     = '0;
    m_shadow  = '0;
    m_scratch = '0;
    m_freeze  = 1'b0;
  endtask

  task automatic check_out(input string tag);
    logic exp_v;
    exp_v = (q_a.size() != 0);
    chk({tag, " valid"}, {31'b0, readdatavalid_a}, {31'b0, exp_v});
    if (exp_v) last_a = q_a.pop_front();
    chk({tag, " data"}, readdata_a, last_a);
    exp_v = (q_b.size() != 0);
    chk({tag, " valid(u)"}, {31'b0, readdatavalid_b}, {31'b0, exp_v});
    if (exp_v) last_b = q_b.pop_front();
    chk({tag, " data(u)"}, readdata_b, last_b);
  endtask

  // Drive one cycle of stimulus and advance the model across the coming edge
  task automatic drive(input logic rn, input logic rd, input logic wr, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    logic clr;
    reset_n    = rn;
    read       = rd;
    write      = wr;
    address    = a;
    writedata  = d;
    byteenable = be;
    if (!rn) begin
      model_reset();
      return;
    end
    if (rd) begin
      q_a.push_back(model_rd(a, 1'b0));
      q_b.push_back(model_rd(a, 1'b1));
    end
    if (rd && a == 4'd4) m_shadow = m_cnt[63:32];
    if (wr && a == 4'd3) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
    end
    clr = wr && (a == 4'd6) && be[0] && d[0];
    if (clr) m_cnt = '0;
    else if (!m_freeze) m_cnt = m_cnt + 64'd1;
    if (wr && a == 4'd6 && be[0]) m_freeze = d[1];
  endtask

  task automatic step(input string tag, input logic rn, input logic rd, input logic wr,
                      input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    check_out(tag);
    drive(rn, rd, wr, a, d, be);
  endtask

  task automatic rd_(input string tag, input logic [3:0] a);
    step(tag, 1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic wr_(input string tag, input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] be);
    step(tag, 1'b1, 1'b0, 1'b1, a, d, be);
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) step(tag, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  initial begin
    repeat (3) step("reset", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    idle("release", 1);

    rd_("id", 4'd0);
    rd_("timestamp", 4'd1);
    rd_("caps", 4'd2);
    idle("post_id", 2);

    wr_("scr_zero", 4'd3, 32'h0, 4'hF);
    wr_("scr_lanes", 4'd3, 32'hDEAD_BEEF, 4'b0101);
    rd_("scr_rd", 4'd3);
    wr_("scr_be0", 4'd3, 32'hFFFF_FFFF, 4'b0000);
    rd_("scr_rd_be0", 4'd3);
    step("scr_rw", 1'b1, 1'b1, 1'b1, 4'd3, 32'h1234_5678, 4'hF);
    rd_("scr_rd_after_rw", 4'd3);
    wr_("ro_write", 4'd0, 32'hFFFF_FFFF, 4'hF);
    rd_("id_after_wr", 4'd0);
    rd_("reserved7", 4'd7);
    rd_("beyond_user", 4'd12);

    rd_("uptime_lo", 4'd4);
    rd_("uptime_hi", 4'd5);

    wr_("ctl_lane_hi", 4'd6, 32'h2, 4'b1110);
    rd_("ctl_ignored", 4'd6);
    wr_("freeze", 4'd6, 32'h2, 4'hF);
    idle("frozen", 10);
    rd_("lo_frozen1", 4'd4);
    rd_("lo_frozen2", 4'd4);
    rd_("ctl_frozen", 4'd6);
    wr_("clear", 4'd6, 32'h1, 4'hF);
    rd_("lo_cleared", 4'd4);
    rd_("ctl_cleared", 4'd6);

    // Counter forced to 2^32-1 across the UPTIME_LO read edge
    @(negedge clock);
    check_out("force_pre");
    force dut.u_uptime.r_count = 64'h0000_0000_FFFF_FFFF;
    force dut_u.u_uptime.r_count = 64'h0000_0000_FFFF_FFFF;
    m_cnt = 64'h0000_0000_FFFF_FFFF;
    drive(1'b1, 1'b1, 1'b0, 4'd4, 32'h0, 4'h0);
    @(negedge clock);
    check_out("force_lo");
    release dut.u_uptime.r_count;
    release dut_u.u_uptime.r_count;
    drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    wr_("force_hi", 4'd6, 32'h1, 4'hF);
    rd_("lo_cleared2", 4'd4);

    rd_("user8", 4'd8);
    rd_("user9", 4'd9);
    rd_("user10", 4'd10);
    rd_("user15", 4'd15);
    idle("user_drain", 1);

    wr_("scr_pre_rst", 4'd3, 32'hCAFE_F00D, 4'hF);
    rd_("scr_pending", 4'd3);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    model_reset();
    step("rst_hold", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    step("rst_hold2", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    idle("rst_release", 1);
    rd_("scr_after_rst", 4'd3);
    rd_("lo_after_rst", 4'd4);
    idle("final", 2);
    chk("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
